// File: rtl/bcd_e3_seq_ctrl.sv
// Digit-serial 8421 -> Excess-3 sequencer: walks a packed BCD word LSD first
// through one shared external converter and returns the assembled result.
module bcd_e3_seq_ctrl #(
   parameter int NDIG = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4*NDIG-1:0]   bcd_in,
   output logic [3:0]          dp_bcd,
   input  logic [3:0]          dp_s,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*NDIG-1:0]   e3_out,
   output logic [NDIG-1:0]     err_mask,
   output logic                err,
   output logic                busy
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   logic [IW-1:0]       idx;
   logic [4*NDIG-1:0]   pend;

   function automatic logic bcd_invalid(input logic [3:0] d);
      return (d > 4'd9);
   endfunction

   assign err = |err_mask;

   // pend holds the digits not yet presented; dp_bcd is always the digit at idx
   // while in CONV, so the converter output can be stored on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         e3_out    <= '0;
         err_mask  <= '0;
         dp_bcd    <= 4'd0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  pend      <= bcd_in >> 4;
                  dp_bcd    <= bcd_in[3:0];
                  e3_out    <= '0;
                  err_mask  <= '0;
                  idx       <= '0;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  state     <= CONV;
               end
            end
            CONV: begin
               for (int i = 0; i < NDIG; i++) begin
                  if (idx == IW'(i)) begin
                     e3_out[4*i +: 4] <= dp_s;
                     err_mask[i]      <= bcd_invalid(dp_bcd);
                  end
               end
               if (idx == LAST) begin
                  dp_bcd    <= 4'd0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx    <= idx + 1'b1;
                  dp_bcd <= pend[3:0];
                  pend   <= pend >> 4;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               dp_bcd    <= 4'd0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
